// File: rtl/frame_sched_pkg.sv
// Shared types and timing helpers for the frame scheduler.
package frame_sched_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, HOLD} fs_state_t;

   localparam int unsigned CLEAR_CYCLES = 2;

   // One network slot: two full weight sweeps plus two settle cycles.
   function automatic int unsigned slot_cycles(input int unsigned width);
      return (32'd1 << (width + 32'd1)) + 32'd2;
   endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Frame input and result output handshakes of the frame scheduler.
interface frame_scheduler_if #(
   parameter int unsigned HEIGHT = 7,
   parameter int unsigned BAL_W  = 11
);
   logic              frame_valid;
   logic              frame_ready;
   logic [HEIGHT-1:0] frame_pixels;
   logic              result_valid;
   logic              result_ready;
   logic [BAL_W-1:0]  result_balance;
   logic              result_neuron;

   modport master (
      output frame_valid, frame_pixels, result_ready,
      input  frame_ready, result_valid, result_balance, result_neuron
   );

   modport slave (
      input  frame_valid, frame_pixels, result_ready,
      output frame_ready, result_valid, result_balance, result_neuron
   );
endinterface

// File: rtl/run_timer.sv
// Evaluation timer: cleared by load, counts while enabled, flags the final run cycle.
module run_timer #(
   parameter int unsigned COUNT = 3598
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic last_c
);
   localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

   logic [CNT_W-1:0] count;

   assign last_c = enable && (count == CNT_W'(COUNT - 1));

   // Holds at the terminal value instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable && !last_c) begin
         count <= count + CNT_W'(1);
      end
   end
endmodule

// File: rtl/frame_scheduler.sv
// Sequences the stochastic neuron network frame by frame: buffers one frame,
// resets and times the network evaluation, then presents balance/decision.
module frame_scheduler
   import frame_sched_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned HEIGHT = 7,
   parameter int unsigned BAL_W  = $clog2(HEIGHT * ((2 ** WIDTH) - 1) + 1)
) (
   input  logic              clk,
   input  logic              rst,
   frame_scheduler_if.slave  bus,
   output logic [HEIGHT-1:0] net_pixels,
   output logic              net_rst_n,
   input  logic [BAL_W-1:0]  balance_in,
   input  logic              neuron_in,
   output logic              busy
);
   localparam int unsigned SLOT       = slot_cycles(WIDTH);
   localparam int unsigned RUN_CYCLES = HEIGHT * SLOT;
   localparam int unsigned CLR_W      = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

   fs_state_t         state, state_next;
   logic [HEIGHT-1:0] pending_pixels;
   logic [CLR_W-1:0]  clr_cnt;
   logic              pending_full;
   logic              accept_c, load_c, consume_c, run_en_c, run_last_c;

   // frame_ready is the inverted pending-full flag, so it never depends on frame_valid.
   assign pending_full = !bus.frame_ready;
   assign accept_c     = bus.frame_valid && bus.frame_ready;
   assign run_en_c     = (state == RUN);

   run_timer #(.COUNT(RUN_CYCLES)) u_run_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (load_c),
      .enable (run_en_c),
      .last_c (run_last_c)
   );

   // Next-state and load/consume strobes.
   always_comb begin
      state_next = state;
      load_c     = 1'b0;
      consume_c  = 1'b0;
      case (state)
         IDLE: begin
            if (pending_full) begin
               load_c     = 1'b1;
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) state_next = RUN;
         end
         RUN: begin
            if (run_last_c) state_next = CAPTURE;
         end
         CAPTURE: state_next = HOLD;
         HOLD: begin
            if (bus.result_ready) begin
               consume_c = 1'b1;
               if (pending_full) begin
                  load_c     = 1'b1;
                  state_next = CLEAR;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Accept and load are exclusive: one needs the buffer empty, the other full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.frame_ready <= 1'b1;
         pending_pixels  <= '0;
      end else if (load_c) begin
         bus.frame_ready <= 1'b1;
      end else if (accept_c) begin
         bus.frame_ready <= 1'b0;
         pending_pixels  <= bus.frame_pixels;
      end
   end

   // Network drive; net_pixels moves only on a load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         net_pixels <= '0;
         net_rst_n  <= 1'b0;
         busy       <= 1'b0;
         clr_cnt    <= '0;
      end else begin
         if (load_c) net_pixels <= pending_pixels;
         net_rst_n <= (state_next == RUN) || (state_next == CAPTURE);
         busy      <= (state_next != IDLE);
         clr_cnt   <= ((state == CLEAR) && (state_next == CLEAR)) ? clr_cnt + CLR_W'(1) : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.result_valid   <= 1'b0;
         bus.result_balance <= '0;
         bus.result_neuron  <= 1'b0;
      end else if (state == CAPTURE) begin
         bus.result_valid   <= 1'b1;
         bus.result_balance <= balance_in;
         bus.result_neuron  <= neuron_in;
      end else if (consume_c) begin
         bus.result_valid   <= 1'b0;
      end
   end
endmodule
